sha256_padder: RTL and testbench

Upstream message-formatting stage for the SHA-256 datapath. Accepts a message as a stream of big-endian 32-bit words and emits 512-bit chunks with FIPS 180-4 padding applied: a 0x80 byte, zero fill, and the 64-bit message bit-length. It feeds the `chunk_data` valid/ready port of the transform stage. The `chunk_first`/`chunk_last` sideband lets the context logic choose the initial H values and identify the final digest.

---
 rtl/sha256_pkg.sv | 15 +
 rtl/sha256_pad_word.sv | 29 ++
 rtl/sha256_padder.sv | 179 +++++++++++++++++
 tb/tb_sha256_padder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants, chunk type and padder state encoding (rev 1.0)
`default_nettype none
package sha256_pkg;
  localparam int         SHA256_CHUNK_BITS = 512;
  localparam logic [7:0] SHA256_PAD_BYTE   = 8'h80;

  typedef logic [15:0][31:0] chunk_t;

  typedef enum logic [1:0] {
    ST_FILL       = 2'd0,
    ST_EMIT       = 2'd1,
    ST_EMIT_EXTRA = 2'd2
  } padder_state_e;
endpackage
`default_nettype wire

// File: rtl/sha256_pad_word.sv
// sha256_pad_word: keeps the first nbytes of a big-endian word and appends 0x80 (rev 1.0)
`default_nettype none
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  nbytes,
  output logic [31:0] word,
  output logic        pad_next
);

  always_comb begin
    word     = '0;
    pad_next = 1'b0;
    case (nbytes)
      3'd0: word = {SHA256_PAD_BYTE, 24'h0};
      3'd1: word = {data[31:24], SHA256_PAD_BYTE, 16'h0};
      3'd2: word = {data[31:16], SHA256_PAD_BYTE, 8'h0};
      3'd3: word = {data[31:8], SHA256_PAD_BYTE};
      default: begin
        // full word: the pad byte spills into the following word
        word     = data;
        pad_next = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sha256_padder.sv
// sha256_padder: FIPS 180-4 padder, 32-bit words in, 512-bit chunks out (rev 1.0)
// Define SHA256_PADDER_ERR_EN to add the sticky err output.
`default_nettype none
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int CNT_W = 61
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic [31:0]                  in_data,
  input  logic                         in_last,
  input  logic [2:0]                   in_bytes,
  output logic                         chunk_data_vld,
  input  logic                         chunk_data_rdy,
  output logic [SHA256_CHUNK_BITS-1:0] chunk_data,
  output logic                         chunk_first,
  output logic                         chunk_last
`ifdef SHA256_PADDER_ERR_EN
  ,output logic                        err
`endif
);

  padder_state_e    state, state_nxt;
  chunk_t           buf_q, buf_last, buf_extra;
  logic [3:0]       widx;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             first_q, last_q, extra_q, pend80;

  logic [2:0]  n_eff, add;
  logic [31:0] word_pad;
  logic        pad_next;
  logic [4:0]  free_idx;
  logic [63:0] len_fill, len_cur;
  logic        accept, hs;

  assign n_eff  = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign add    = in_last ? n_eff : 3'd4;
  assign accept = in_vld && in_rdy;
  assign hs     = chunk_data_vld && chunk_data_rdy;

`ifdef SHA256_PADDER_ERR_EN
  logic carry;
  assign {carry, cnt_nxt} = {1'b0, cnt} + (CNT_W+1)'(add);
`else
  assign cnt_nxt = cnt + CNT_W'(add);
`endif

  assign len_fill = 64'(cnt_nxt) << 3;
  assign len_cur  = 64'(cnt) << 3;
  assign free_idx = {1'b0, widx} + 5'd1 + 5'(pad_next && (widx != 4'd15));

  sha256_pad_word u_pad_word (
    .data     (in_data),
    .nbytes   (n_eff),
    .word     (word_pad),
    .pad_next (pad_next)
  );

  // Message word w lives at packed index 15-w, so word 0 lands in the top bits.
  always_comb begin
    buf_last = buf_q;
    for (int w = 0; w < 16; w++) begin
      if (5'(w) == {1'b0, widx})
        buf_last[15-w] = word_pad;
      else if (5'(w) > {1'b0, widx})
        buf_last[15-w] = (pad_next && (5'(w) == {1'b0, widx} + 5'd1)) ?
                         {SHA256_PAD_BYTE, 24'h0} : 32'h0;
    end
    if (free_idx <= 5'd14) begin
      buf_last[1] = len_fill[63:32];
      buf_last[0] = len_fill[31:0];
    end
  end

  always_comb begin
    buf_extra     = '0;
    buf_extra[15] = pend80 ? {SHA256_PAD_BYTE, 24'h0} : 32'h0;
    buf_extra[1]  = len_cur[63:32];
    buf_extra[0]  = len_cur[31:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_FILL;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    in_rdy         = 1'b0;
    chunk_data_vld = 1'b0;
    case (state)
      ST_FILL: begin
        in_rdy = 1'b1;
        if (in_vld && (in_last || widx == 4'd15)) state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        chunk_data_vld = 1'b1;
        if (chunk_data_rdy) state_nxt = extra_q ? ST_EMIT_EXTRA : ST_FILL;
      end
      ST_EMIT_EXTRA: begin
        chunk_data_vld = 1'b1;
        if (chunk_data_rdy) state_nxt = ST_FILL;
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q   <= '0;
      widx    <= '0;
      cnt     <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      extra_q <= 1'b0;
      pend80  <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (accept) begin
            cnt <= cnt_nxt;
            if (in_last) begin
              buf_q   <= buf_last;
              last_q  <= (free_idx <= 5'd14);
              extra_q <= (free_idx > 5'd14);
              pend80  <= pad_next && (widx == 4'd15);
            end else begin
              buf_q[~widx] <= in_data;
              widx         <= widx + 4'd1;
            end
          end
        end
        ST_EMIT: begin
          if (hs) begin
            first_q <= 1'b0;
            widx    <= '0;
            if (extra_q) begin
              // the trailing length-only chunk reuses the buffer and last flag
              buf_q  <= buf_extra;
              last_q <= 1'b1;
            end else if (last_q) begin
              cnt     <= '0;
              first_q <= 1'b1;
              last_q  <= 1'b0;
            end
          end
        end
        ST_EMIT_EXTRA: begin
          if (hs) begin
            extra_q <= 1'b0;
            pend80  <= 1'b0;
            cnt     <= '0;
            first_q <= 1'b1;
            last_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHA256_PADDER_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err <= 1'b0;
    else if (state == ST_FILL && accept && ((in_last && in_bytes > 3'd4) || carry))
      err <= 1'b1;
  end
`endif

  assign chunk_data  = buf_q;
  assign chunk_first = first_q;
  assign chunk_last  = last_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: random and directed messages checked against a byte-level padding model.
`default_nettype none
module tb_sha256_padder;

  localparam int LIMIT = 300;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_vld = 1'b0;
  logic         in_rdy;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [2:0]   in_bytes = '0;
  logic         chunk_data_vld;
  logic         chunk_data_rdy = 1'b0;
  logic [511:0] chunk_data;
  logic         chunk_first;
  logic         chunk_last;

  int checks = 0;
  int errors = 0;

  logic [7:0]   msg_q[$];
  logic [511:0] exp_q[$];

  sha256_padder #(.CNT_W(61)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_vld         (in_vld),
    .in_rdy         (in_rdy),
    .in_data        (in_data),
    .in_last        (in_last),
    .in_bytes       (in_bytes),
    .chunk_data_vld (chunk_data_vld),
    .chunk_data_rdy (chunk_data_rdy),
    .chunk_data     (chunk_data),
    .chunk_first    (chunk_first),
    .chunk_last     (chunk_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Message bytes, 0x80, zeros to 56 mod 64, then the 64-bit big-endian bit length.
  task automatic build_expected();
    logic [7:0]   p[$];
    logic [63:0]  bitlen;
    logic [511:0] v;
    p = msg_q;
    bitlen = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int b = 7; b >= 0; b--) p.push_back(bitlen[8*b +: 8]);
    exp_q.delete();
    for (int c = 0; c < p.size() / 64; c++) begin
      v = '0;
      for (int j = 0; j < 64; j++) v[511-8*j -: 8] = p[64*c+j];
      exp_q.push_back(v);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_in_rdy"}, 512'(in_rdy), 512'd1);
    check_eq({tag, "_vld"},    512'(chunk_data_vld), 512'd0);
    check_eq({tag, "_first"},  512'(chunk_first), 512'd1);
    check_eq({tag, "_last"},   512'(chunk_last), 512'd0);
    check_eq({tag, "_data"},   chunk_data, 512'd0);
  endtask

  task automatic drive_msg();
    int len = msg_q.size();
    int nw  = (len == 0) ? 1 : (len + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      logic [31:0] w;
      bit last = (k == nw - 1);
      int nb   = last ? len - 4 * k : 4;
      int t    = 0;
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_vld = 1'b0;
      end
      @(negedge clk);
      w = $urandom;
      for (int b = 0; b < 4; b++)
        if (4 * k + b < len) w[31-8*b -: 8] = msg_q[4*k+b];
      in_data  = w;
      in_vld   = 1'b1;
      in_last  = last;
      if (last && nb < 4) in_bytes = 3'(nb);
      else if (last)      in_bytes = 3'($urandom_range(4, 7));
      else                in_bytes = 3'($urandom_range(0, 7));
      while (!in_rdy && t < LIMIT) begin
        @(negedge clk);
        t++;
      end
      if (!in_rdy) begin
        check_eq("in_rdy_timeout", 512'd0, 512'd1);
        in_vld = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (last || (k % 16) == 15) check_eq("latency_vld", 512'(chunk_data_vld), 512'd1);
    end
    @(negedge clk);
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic collect(input bit hold);
    int n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      logic [511:0] snap;
      int t = 0;
      int hn;
      chunk_data_rdy = 1'b0;
      @(negedge clk);
      while (!chunk_data_vld && t < LIMIT) begin
        @(negedge clk);
        t++;
      end
      if (!chunk_data_vld) begin
        check_eq("chunk_timeout", 512'd0, 512'd1);
        return;
      end
      check_eq("chunk_data",  chunk_data, exp_q[c]);
      check_eq("chunk_first", 512'(chunk_first), 512'(c == 0));
      check_eq("chunk_last",  512'(chunk_last), 512'(c == n - 1));
      check_eq("in_rdy_emit", 512'(in_rdy), 512'd0);
      snap = chunk_data;
      hn = hold ? 5 : $urandom_range(0, 2);
      repeat (hn) begin
        @(negedge clk);
        if (hold) begin
          check_eq("hold_data",   chunk_data, snap);
          check_eq("hold_vld",    512'(chunk_data_vld), 512'd1);
          check_eq("hold_in_rdy", 512'(in_rdy), 512'd0);
        end
      end
      chunk_data_rdy = 1'b1;
      @(posedge clk);
      #1;
      chunk_data_rdy = 1'b0;
    end
    @(negedge clk);
    check_eq("no_extra_chunk", 512'(chunk_data_vld), 512'd0);
  endtask

  task automatic run_msg(input bit hold);
    build_expected();
    fork
      drive_msg();
      collect(hold);
    join
  endtask

  task automatic random_bytes(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b1;
    @(negedge clk);

    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(1'b0);
    check_eq("abc_word0", exp_q[0][511:480], 512'h61626380);

    msg_q.delete();
    run_msg(1'b0);
    random_bytes(55);
    run_msg(1'b0);
    random_bytes(56);
    run_msg(1'b0);
    random_bytes(64);
    run_msg(1'b0);

    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(1'b1);

    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      in_vld   = 1'b1;
      in_last  = 1'b0;
      in_data  = $urandom;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    in_vld = 1'b0;
    rst    = 1'b0;
    #1;
    check_reset_state("midmsg_reset");
    @(negedge clk);
    rst = 1'b1;
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(1'b0);

    for (int m = 0; m < 30; m++) begin
      random_bytes($urandom_range(0, 200));
      run_msg(1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
